// File: rtl/bitty_ctrl_seq.sv
// ============================================================================
// Module   : bitty_ctrl_seq
// Purpose  : LOAD/COMPUTE/WRITEBACK instruction sequencer for the BittyPro
//            datapath. It supports reg-reg and reg-imm formats, flags illegal
//            register indices, and allows back-to-back issue.
// Options  : define BITTY_CTRL_IMM_SEXT_EN to sign-extend imm_value instead of
//            zero-extending it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitty_ctrl_seq #(
    parameter  int NUM_REGS = 8,
    parameter  int INST_W   = 16,
    parameter  int DATA_W   = 16,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int IMM_W    = INST_W - REG_W - 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INST_W-1:0]   inst,
    input  logic                inst_valid,
    output logic                inst_ready,
    output logic [3:0]          sel,
    output logic                mode,
    output logic [REG_W:0]      mux_sel,
    output logic [DATA_W-1:0]   imm_value,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic                S_enable,
    output logic                C_enable,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_COMPUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [REG_W:0]      c_IMM_SEL = (REG_W+1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] c_ONE     = NUM_REGS'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [INST_W-1:0]   r_inst_q;
    logic                r_run;

    logic [REG_W-1:0]    w_rx;
    logic [REG_W-1:0]    w_ry;
    logic [IMM_W-1:0]    w_imm;
    logic                w_fmt;
    logic                w_ready;
    logic                w_accept;
    logic                w_dst_bad;
    logic                w_src_bad;

    assign w_rx  = r_inst_q[INST_W-1 -: REG_W];
    assign w_ry  = r_inst_q[INST_W-1-REG_W -: REG_W];
    assign w_imm = r_inst_q[INST_W-1-REG_W : 6];
    assign w_fmt = r_inst_q[0];

    assign sel  = r_inst_q[5:2];
    assign mode = r_inst_q[1];

    // Index checks only bite when NUM_REGS is not a power of two.
    assign w_dst_bad = ({1'b0, w_rx} >= c_IMM_SEL);
    assign w_src_bad = !w_fmt && ({1'b0, w_ry} >= c_IMM_SEL);

    // r_run keeps inst_ready low while reset is held.
    assign w_ready    = r_run && ((r_state == S_IDLE) || (r_state == S_WRITEBACK));
    assign inst_ready = w_ready;
    assign w_accept   = inst_valid && w_ready;

    generate
        if (IMM_W >= DATA_W) begin : g_imm_trunc
            assign imm_value = w_imm[DATA_W-1:0];
        end else begin : g_imm_ext
`ifdef BITTY_CTRL_IMM_SEXT_EN
            assign imm_value = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
`else
            assign imm_value = {{(DATA_W-IMM_W){1'b0}}, w_imm};
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_run    <= 1'b0;
            r_inst_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_accept) begin
                r_inst_q <= inst;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mux_sel     = '0;
        reg_enable  = '0;
        S_enable    = 1'b0;
        C_enable    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                mux_sel     = {1'b0, w_rx};
                S_enable    = 1'b1;
                w_state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_fmt) begin
                    mux_sel = c_IMM_SEL;
                end else if (!w_src_bad) begin
                    mux_sel = {1'b0, w_ry};
                end
                C_enable    = 1'b1;
                w_state_nxt = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                done = 1'b1;
                err  = w_dst_bad || w_src_bad;
                if (!w_dst_bad) begin
                    reg_enable = c_ONE << w_rx;
                end
                w_state_nxt = w_accept ? S_LOAD : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bitty_ctrl_seq.sv
// ============================================================================
// Module   : tb_bitty_ctrl_seq
// Purpose  : Scoreboard bench for bitty_ctrl_seq (default and NUM_REGS=6).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitty_ctrl_seq;

`ifdef BITTY_CTRL_IMM_SEXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    typedef struct {
        int          t_acc;
        logic [4:0]  ms_s;
        logic [4:0]  ms_c;
        logic [15:0] imm;
        logic [3:0]  sel;
        logic        mode;
        logic [15:0] ren;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   ncyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    // DUT 0: default parameters
    logic [15:0] i0_inst;
    logic        i0_valid, o0_ready, o0_mode, o0_s, o0_c, o0_done, o0_err;
    logic [3:0]  o0_sel;
    logic [3:0]  o0_ms;
    logic [15:0] o0_imm;
    logic [7:0]  o0_ren;

    // DUT 1: NUM_REGS = 6
    logic [15:0] i1_inst;
    logic        i1_valid, o1_ready, o1_mode, o1_s, o1_c, o1_done, o1_err;
    logic [3:0]  o1_sel;
    logic [3:0]  o1_ms;
    logic [15:0] o1_imm;
    logic [5:0]  o1_ren;

    bitty_ctrl_seq u_dut0 (
        .clk(clk), .reset(reset), .inst(i0_inst), .inst_valid(i0_valid),
        .inst_ready(o0_ready), .sel(o0_sel), .mode(o0_mode), .mux_sel(o0_ms),
        .imm_value(o0_imm), .reg_enable(o0_ren), .S_enable(o0_s),
        .C_enable(o0_c), .done(o0_done), .err(o0_err)
    );

    bitty_ctrl_seq #(.NUM_REGS(6)) u_dut1 (
        .clk(clk), .reset(reset), .inst(i1_inst), .inst_valid(i1_valid),
        .inst_ready(o1_ready), .sel(o1_sel), .mode(o1_mode), .mux_sel(o1_ms),
        .imm_value(o1_imm), .reg_enable(o1_ren), .S_enable(o1_s),
        .C_enable(o1_c), .done(o1_done), .err(o1_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] ms_s, input logic [4:0] ms_c,
                                input logic [6:0] imm7, input logic [3:0] sl,
                                input logic md, input logic [15:0] ren, input logic er);
        exp_t e;
        e.t_acc = 0;
        e.ms_s  = ms_s;
        e.ms_c  = ms_c;
        e.imm   = (SEXT && imm7[6]) ? {9'h1FF, imm7} : {9'h000, imm7};
        e.sel   = sl;
        e.mode  = md;
        e.ren   = ren;
        e.err   = er;
        return e;
    endfunction

    task automatic mon(input int id, input logic s, input logic c, input logic d,
                       input logic e, input logic [4:0] ms, input logic [3:0] sl,
                       input logic md, input logic [15:0] imm, input logic [15:0] ren);
        exp_t h;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        if (s || c || d) begin
            chk($sformatf("dut%0d_one_enable", id), 32'(s) + 32'(c) + 32'(d), 1);
            if (sz == 0) begin
                chk($sformatf("dut%0d_unexpected_enable", id), {29'd0, s, c, d}, 0);
            end else begin
                if (id == 0) h = q0[0]; else h = q1[0];
                if (s) begin
                    chk($sformatf("dut%0d_s_latency", id), ncyc, h.t_acc + 1);
                    chk($sformatf("dut%0d_load_mux", id), ms, h.ms_s);
                end
                if (c) begin
                    chk($sformatf("dut%0d_c_latency", id), ncyc, h.t_acc + 2);
                    chk($sformatf("dut%0d_compute_mux", id), ms, h.ms_c);
                    chk($sformatf("dut%0d_imm_value", id), imm, h.imm);
                    chk($sformatf("dut%0d_sel_mode", id), {sl, md}, {h.sel, h.mode});
                end
                if (d) begin
                    chk($sformatf("dut%0d_done_latency", id), ncyc, h.t_acc + 3);
                    chk($sformatf("dut%0d_wb_reg_enable", id), ren, h.ren);
                    chk($sformatf("dut%0d_wb_err", id), e, h.err);
                    chk($sformatf("dut%0d_wb_mux", id), ms, 0);
                    chk($sformatf("dut%0d_wb_sel_mode", id), {sl, md}, {h.sel, h.mode});
                    if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end else if (e || (ren != 16'd0)) begin
            chk($sformatf("dut%0d_stray_err_ren", id), {e, ren}, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, o0_s, o0_c, o0_done, o0_err, {1'b0, o0_ms}, o0_sel, o0_mode, o0_imm, {8'd0, o0_ren});
        mon(1, o1_s, o1_c, o1_done, o1_err, {1'b0, o1_ms}, o1_sel, o1_mode, o1_imm, {10'd0, o1_ren});
    end

    // Called right after a negedge; returns at the negedge following the accept.
    task automatic issue(input int id, input logic [15:0] v, input exp_t e,
                         input bit hold, output int t_acc);
        exp_t  x;
        logic  rdy;
        x = e;
        if (id == 0) begin i0_inst = v; i0_valid = 1'b1; end
        else         begin i1_inst = v; i1_valid = 1'b1; end
        rdy = (id == 0) ? o0_ready : o1_ready;
        for (int k = 0; k < 20 && !rdy; k++) begin
            @(negedge clk);
            rdy = (id == 0) ? o0_ready : o1_ready;
        end
        t_acc = ncyc;
        if (!rdy) begin
            chk($sformatf("dut%0d_accept_timeout", id), 0, 1);
        end else begin
            x.t_acc = ncyc;
            if (id == 0) q0.push_back(x); else q1.push_back(x);
        end
        @(negedge clk);
        if (!hold) begin
            if (id == 0) begin i0_valid = 1'b0; i0_inst = 16'($urandom); end
            else         begin i1_valid = 1'b0; i1_inst = 16'($urandom); end
        end
    endtask

    int acc[4];
    int t;

    initial begin
        reset = 1'b0;
        i0_inst = '0; i0_valid = 1'b0;
        i1_inst = '0; i1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready_low", {o0_ready, o1_ready}, 0);
        chk("reset_outputs", {o0_s, o0_c, o0_done, o0_err, o0_ms, o0_sel, o0_mode, o0_ren}, 0);
        chk("reset_imm", o0_imm, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {o0_ready, o1_ready}, 2'b11);

        // Reg-reg: Rx=2 Ry=3 sel=2 mode=1, then inst toggles without accept
        issue(0, 16'h4C0A, mk(5'd2, 5'd3, 7'h30, 4'd2, 1'b1, 16'h0004, 1'b0), 0, t);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i0_inst = 16'($urandom);
        end
        repeat (2) @(negedge clk);

        // Reg-imm: Rx=5 imm=7F
        issue(0, 16'hBFCD, mk(5'd5, 5'd8, 7'h7F, 4'd3, 1'b0, 16'h0020, 1'b0), 0, t);
        repeat (4) @(negedge clk);

        // Back-to-back with inst_valid held high
        issue(0, 16'h0404, mk(5'd0, 5'd1, 7'h10, 4'd1, 1'b0, 16'h0001, 1'b0), 1, acc[0]);
        issue(0, 16'hF83E, mk(5'd7, 5'd6, 7'h60, 4'hF, 1'b1, 16'h0080, 1'b0), 1, acc[1]);
        issue(0, 16'h6055, mk(5'd3, 5'd8, 7'h01, 4'd5, 1'b0, 16'h0008, 1'b0), 1, acc[2]);
        issue(0, 16'h3023, mk(5'd1, 5'd8, 7'h40, 4'd8, 1'b1, 16'h0002, 1'b0), 1, acc[3]);
        i0_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk($sformatf("b2b_accept_gap_%0d", i), acc[i] - acc[0], 3 * i);
        repeat (5) @(negedge clk);

        // NUM_REGS=6: illegal destination, illegal source, then a legal one
        issue(1, 16'hE001, mk(5'd7, 5'd6, 7'h00, 4'd0, 1'b0, 16'h0000, 1'b1), 0, t);
        issue(1, 16'h5800, mk(5'd2, 5'd0, 7'h60, 4'd0, 1'b0, 16'h0004, 1'b1), 0, t);
        issue(1, 16'hB000, mk(5'd5, 5'd4, 7'h40, 4'd0, 1'b0, 16'h0020, 1'b0), 0, t);
        repeat (5) @(negedge clk);

        // Reset during COMPUTE discards the instruction
        issue(0, 16'h4C0A, mk(5'd2, 5'd3, 7'h30, 4'd2, 1'b1, 16'h0004, 1'b0), 0, t);
        @(negedge clk);
        #2;
        reset = 1'b0;
        q0.delete();
        #1;
        chk("async_reset_enables", {o0_s, o0_c, o0_done, o0_err, o0_ren}, 0);
        chk("async_reset_mux_sel_mode", {o0_ms, o0_sel, o0_mode}, 0);
        chk("async_reset_imm", o0_imm, 0);
        chk("async_reset_ready", o0_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", o0_ready, 1);
        repeat (6) @(negedge clk);

        for (int k = 0; k < 20 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/bitty_ctrl_seq.md
Name: bitty_ctrl_seq

Overview:
- Parametrised instruction sequencer for the BittyPro datapath. Replaces the fixed 3-state, 8-register control unit.
- Accepts one instruction per valid/ready handshake and latches it.
- Drives the register-file source mux, S/C latch enables and the one-hot writeback enable through a LOAD / COMPUTE / WRITEBACK sequence.
- Adds a register-immediate format, an illegal-destination error, and back-to-back issue (a new accept is allowed in the WRITEBACK cycle).

Parameters:
- NUM_REGS, 8, number of architectural registers (2..16; need not be a power of two).
- INST_W, 16, instruction width.
- DATA_W, 16, datapath width of the imm_value output.
- REG_W, $clog2(NUM_REGS) (derived, not overridable), register index width.
- IMM_W, INST_W-REG_W-6 (derived), immediate field width (7 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  INST_W  instruction, sampled only on accept.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  sequencer can accept.
- sel  out  4  ALU operation select.
- mode  out  1  ALU mode bit.
- mux_sel  out  REG_W+1  source select: 0..NUM_REGS-1 = register, NUM_REGS = immediate.
- imm_value  out  DATA_W  extended immediate to the datapath mux.
- reg_enable  out  NUM_REGS  one-hot register write enable.
- S_enable  out  1  S latch load.
- C_enable  out  1  C (result) latch load.
- done  out  1  one-cycle retire pulse.
- err  out  1  one-cycle illegal-instruction pulse, coincident with done.

Behaviour:
- Instruction fields, taken from the latched copy inst_q:
  - Rx = inst_q[INST_W-1 -: REG_W]
  - Ry = inst_q[INST_W-1-REG_W -: REG_W]
  - imm = inst_q[INST_W-1-REG_W : 6]
  - sel = inst_q[5:2], mode = inst_q[1], fmt = inst_q[0] (0 = reg-reg, 1 = reg-imm).
- States:
  - IDLE: inst_ready=1.
  - LOAD: mux_sel=Rx, S_enable=1.
  - COMPUTE: mux_sel = fmt ? NUM_REGS : Ry; C_enable=1.
  - WRITEBACK: reg_enable[Rx]=1, done=1, inst_ready=1.
- Transitions:
  - Accept = inst_valid & inst_ready. On accept, inst_q<=inst and the next state is LOAD.
  - LOAD -> COMPUTE -> WRITEBACK, unconditionally.
  - WRITEBACK -> LOAD on accept, else IDLE. IDLE holds without accept.
- Timing and throughput:
  - Latency from accept edge: S_enable the next cycle, C_enable +2, done +3.
  - Sustained throughput: one instruction per 3 cycles.
- Output decode:
  - All outputs decode only from the state register and inst_q. No combinational path from inst or inst_valid to any output.
  - inst_ready depends on state only.
- sel, mode, imm_value reflect inst_q and hold between instructions. mux_sel is 0 in IDLE and WRITEBACK.
- imm_value = imm zero-extended to DATA_W. If IMM_W > DATA_W, the low DATA_W bits are used.
- Illegal destination (Rx >= NUM_REGS; possible only when NUM_REGS is not a power of two):
  - Sequence runs normally.
  - In WRITEBACK, reg_enable stays all-zero and err=1 with done=1.
- Illegal source (reg-reg with Ry >= NUM_REGS): mux_sel is forced to 0 in COMPUTE and err is pulsed in WRITEBACK.
- inst changing while not accepting has no effect. inst_valid held high with ready low is not an error.
- Reset (reset=0), at any time including mid-instruction:
  - state=IDLE immediately.
  - inst_q, sel, mode, mux_sel, imm_value, reg_enable, S_enable, C_enable, done, err all = 0.
  - inst_ready = 1 once reset releases. A partially executed instruction is discarded, with no writeback.
- Reset value of inst_ready while reset is asserted: 0.

Optional Feature:
- Macro: BITTY_CTRL_IMM_SEXT_EN.
- Defined: imm_value = imm sign-extended from bit IMM_W-1 to DATA_W.
- Undefined: zero-extension as above.
- No other behaviour changes.

Test Plan:
- Reset, then accept inst=16'b010_011_0000_0010_1_0 (Rx=2, Ry=3, sel=2, mode=1, fmt=0) -> the next cycle S_enable=1 with mux_sel=2; then C_enable=1 with mux_sel=3; then reg_enable=8'b0000_0100 with done=1 and err=0.
- Reg-imm: Rx=5, imm=7'h7F, fmt=1 -> COMPUTE has mux_sel=8, imm_value=16'h007F (16'hFFFF with BITTY_CTRL_IMM_SEXT_EN), and reg_enable=8'b0010_0000 at done.
- inst_valid held high with 4 different instructions -> accepts at cycles 0, 3, 6, 9; done at 3, 6, 9, 12; never two enables in one cycle.
- NUM_REGS=6, Rx=7 -> done=1 and err=1 with reg_enable=0. Same instance, reg-reg with Ry=6 -> mux_sel=0 in COMPUTE, err=1.
- Reset asserted during COMPUTE -> all outputs 0 asynchronously, no reg_enable pulse afterwards, and inst_ready=1 on the first cycle after release.
- inst toggling while in COMPUTE, without accept -> outputs unchanged from the latched instruction.
